// File: rtl/sensor_debounce_pkg.sv
// Shared defaults and counter sizing for the sensor input debouncer.
package sensor_pkg;

  localparam int SENSOR_WIDTH           = 3;
  localparam int SENSOR_DEBOUNCE_CYCLES = 50000;

  // Stability counter width: clog2 of the cycle count, never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/sensor_debounce_bit.sv
// One sensor channel: two-flop synchroniser, stability counter, clean level
// and optional edge pulses (SENSOR_DEBOUNCE_EDGE_EN).
module sensor_debounce_bit
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic clean_o
`ifdef SENSOR_DEBOUNCE_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          clean_q, clean_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_s;

  // The synchronised level has disagreed with the clean level long enough.
  assign accept_s = (s2_q != clean_q) && (cnt_q == CNT_MAX);

  // Next-state for synchroniser, counter and clean level.
  always_comb begin
    s1_d    = raw_i;
    s2_d    = s1_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (accept_s) begin
      clean_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

`ifdef SENSOR_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulses coincide with the cycle the clean level first shows the new value.
  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (accept_s) begin
      rise_d = s2_q;
      fall_d = ~s2_q;
    end else begin
      rise_d = 1'b0;
      fall_d = 1'b0;
    end
  end

  // Edge pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/sensor_debounce.sv
// Debounces WIDTH raw sensor lines into clean levels for the PIO in_port.
// Define SENSOR_DEBOUNCE_EDGE_EN to add per-channel rise/fall pulse outputs.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int WIDTH           = SENSOR_WIDTH,
  parameter int DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sensor_raw,
  output logic [WIDTH-1:0] sensor_clean
`ifdef SENSOR_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $fatal(1, "sensor_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
`ifdef SENSOR_DEBOUNCE_EDGE_EN
    sensor_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (sensor_raw[i]),
      .clean_o(sensor_clean[i]),
      .rise_o (rise_pulse[i]),
      .fall_o (fall_pulse[i])
    );
`else
    sensor_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (sensor_raw[i]),
      .clean_o(sensor_clean[i])
    );
`endif
  end

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce (WIDTH=3, DEBOUNCE_CYCLES=4): vector table,
// corner sequences and randomized traffic against a history-window model.
module tb_sensor_debounce;

  localparam int W  = 3;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sensor_raw;
  logic [W-1:0] sensor_clean;
`ifdef SENSOR_DEBOUNCE_EDGE_EN
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
`endif

  int vectors     = 0;
  int miscompares = 0;

  sensor_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_raw  (sensor_raw),
    .sensor_clean(sensor_clean)
`ifdef SENSOR_DEBOUNCE_EDGE_EN
    ,
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the last DC synchronised samples all
  // disagree with the current clean level.
  logic [W-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  bit hist [W][$];

  task automatic model_edge(input logic rst, input logic [W-1:0] raw);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
      for (int c = 0; c < W; c++) hist[c].delete();
    end else begin
      for (int c = 0; c < W; c++) begin
        bit all_diff;
        hist[c].push_back(m_s2[c]);
        if (hist[c].size() > DC) void'(hist[c].pop_front());
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        all_diff = (hist[c].size() == DC);
        for (int j = 0; j < hist[c].size(); j++)
          if (hist[c][j] == m_clean[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_clean[c] = m_s2[c];
          if (m_s2[c]) m_rise[c] = 1'b1;
          else         m_fall[c] = 1'b1;
          hist[c].delete();
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [W-1:0] raw);
    reset      = rst;
    sensor_raw = raw;
    @(posedge clk);
    model_edge(rst, raw);
    #1;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, " clean"}, sensor_clean, m_clean);
`ifdef SENSOR_DEBOUNCE_EDGE_EN
    cmp({tag, " rise"}, rise_pulse, m_rise);
    cmp({tag, " fall"}, fall_pulse, m_fall);
    cmp({tag, " excl"}, rise_pulse & fall_pulse, 3'b000);
`endif
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] clean,
                     input logic [W-1:0] rise, input logic [W-1:0] fall, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.clean = clean; v.rise = rise; v.fall = fall;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    logic [W-1:0] r;
    int rises;

    reset      = 1'b1;
    sensor_raw = '0;

    // reset held 3 cycles with all lines high, then accepted 6 edges after release
    add(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3);
    add(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 5);
    add(1'b0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
    add(1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1);
    add(1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 5);
    add(1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 1);
    add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    // clean step on channel 0
    add(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(1'b0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
    add(1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    // 3-cycle glitch on channel 1 is rejected
    add(1'b0, 3'b011, 3'b001, 3'b000, 3'b000, 3);
    add(1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 6);
    // simultaneous fall on ch0 and rise on ch2
    add(1'b0, 3'b100, 3'b001, 3'b000, 3'b000, 5);
    add(1'b0, 3'b100, 3'b100, 3'b100, 3'b001, 1);
    add(1'b0, 3'b100, 3'b100, 3'b000, 3'b000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].raw);
      cmp($sformatf("tbl%0d clean", i), sensor_clean, tbl[i].clean);
`ifdef SENSOR_DEBOUNCE_EDGE_EN
      cmp($sformatf("tbl%0d rise", i), rise_pulse, tbl[i].rise);
      cmp($sformatf("tbl%0d fall", i), fall_pulse, tbl[i].fall);
`endif
    end

    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'b000);
      check_model("settle");
    end

    // bounce on channel 2: 1,0,1,0 then held high
    rises = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, (k % 2 == 0) ? 3'b100 : 3'b000);
      check_model("bounce");
`ifdef SENSOR_DEBOUNCE_EDGE_EN
      if (rise_pulse[2]) rises++;
`endif
    end
    for (int t = 0; t < 8; t++) begin
      step(1'b0, 3'b100);
      check_model("bounce hold");
      cmp($sformatf("bounce t%0d clean", t), sensor_clean, (t >= 5) ? 3'b100 : 3'b000);
`ifdef SENSOR_DEBOUNCE_EDGE_EN
      if (rise_pulse[2]) rises++;
`endif
    end
`ifdef SENSOR_DEBOUNCE_EDGE_EN
    cmp("bounce rise count", 3'(rises), 3'b001);
`endif

    // reset mid-count, then the held line is re-accepted after full latency
    step(1'b0, 3'b111); check_model("midrst pre");
    step(1'b0, 3'b111); check_model("midrst pre");
    step(1'b1, 3'b111); check_model("midrst rst");
    cmp("midrst rst clean", sensor_clean, 3'b000);
    for (int t = 0; t < 7; t++) begin
      step(1'b0, 3'b111);
      check_model("midrst post");
      cmp($sformatf("midrst t%0d clean", t), sensor_clean, (t >= 5) ? 3'b111 : 3'b000);
`ifdef SENSOR_DEBOUNCE_EDGE_EN
      cmp($sformatf("midrst t%0d rise", t), rise_pulse, (t == 5) ? 3'b111 : 3'b000);
`endif
    end

    r = sensor_raw;
    for (int n = 0; n < 3000; n++) begin
      logic rst;
      for (int c = 0; c < W; c++)
        if ($urandom_range(5) == 0) r[c] = ~r[c];
      rst = ($urandom_range(199) == 0);
      step(rst, r);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
